// File: rtl/op_ext_pipe_if.sv
// Operand-extension pipe handshake bundle: producer side (in_*) and consumer side (out_*).
interface op_ext_pipe_if #(
    parameter int unsigned DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_mode;
    logic [DW-1:0] in_instr;
    logic [DW-1:0] in_pc;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_err;
    logic [1:0]    count;

    modport master (
        output in_valid, in_mode, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_data, out_err, count
    );

    modport slave (
        input  in_valid, in_mode, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_data, out_err, count
    );
endinterface

// File: rtl/op_ext_pipe.sv
// Immediate / jump-target extension unit feeding a 2-entry FIFO.
// The operand is extended combinationally at push; the FIFO head drives the outputs.
module op_ext_pipe #(
    parameter int unsigned DW       = 32,
    parameter int unsigned IMM_W    = 16,
    parameter int unsigned J_W      = 26,
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic         clk,
    input  logic         rst,
    op_ext_pipe_if.slave bus
);
    localparam int unsigned   JB_W       = J_W + BR_SHIFT;
    localparam int unsigned   UP_SHIFT   = DW - IMM_W;
    localparam logic [DW-1:0] PC_HI_MASK = ~((DW'(1) << JB_W) - DW'(1));

    logic [DW-1:0]    mem_data [2];
    logic             mem_err  [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count_q;

    logic [IMM_W-1:0] imm_c;
    logic [DW-1:0]    sext_c;
    logic [DW-1:0]    ext_data_c;
    logic             ext_err_c;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             push_c;
    logic             pop_c;
    logic             unused_instr_hi;

    assign unused_instr_hi = ^bus.in_instr[DW-1:J_W];

    // Extension of the offered instruction according to in_mode
    always_comb begin
        ext_data_c = '0;
        ext_err_c  = 1'b0;
        imm_c      = bus.in_instr[IMM_W-1:0];
        sext_c     = {{UP_SHIFT{imm_c[IMM_W-1]}}, imm_c};
        case (bus.in_mode)
            3'b000:  ext_data_c = DW'(imm_c);
            3'b001:  ext_data_c = sext_c;
            3'b010:  ext_data_c = DW'(imm_c) << UP_SHIFT;
            3'b011:  ext_data_c = DW'(1);
            3'b100:  ext_data_c = (bus.in_pc & PC_HI_MASK)
                                | (DW'(bus.in_instr[J_W-1:0]) << BR_SHIFT);
            3'b101:  ext_data_c = sext_c << BR_SHIFT;
            default: begin
                ext_data_c = '0;
                ext_err_c  = 1'b1;
            end
        endcase
    end

    // Ready is gated by reset so nothing is accepted while rst is held
    assign in_ready_c  = !rst && (count_q != 2'd2);
    assign out_valid_c = (count_q != 2'd0);
    assign push_c      = bus.in_valid && in_ready_c;
    assign pop_c       = out_valid_c && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_err[0]  <= 1'b0;
            mem_err[1]  <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            if (push_c) begin
                mem_data[wr_ptr] <= ext_data_c;
                mem_err[wr_ptr]  <= ext_err_c;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop_c) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = mem_data[rd_ptr];
    assign bus.out_err   = mem_err[rd_ptr];
    assign bus.count     = count_q;
endmodule

// File: doc/op_ext_pipe.md
OP_EXT_PIPE -- requirements
Module: op_ext_pipe

Interface
REQ-001 SHALL provide parameter DW, default 32, datapath and output width.
REQ-002 SHALL provide parameter IMM_W, default 16, immediate field width; IMM_W < DW.
REQ-003 SHALL provide parameter J_W, default 26, jump-target field width; J_W + BR_SHIFT < DW.
REQ-004 SHALL provide parameter BR_SHIFT, default 2, left shift for jump/branch offsets; 0 selects word-addressed memory.
REQ-005 SHALL have one clock, clk, input, 1 bit; all state updates on its rising edge.
REQ-006 SHALL have rst, input, 1 bit, reset; asynchronous, active-high.
REQ-007 SHALL have in_valid, input, 1 bit, producer offers an operand.
REQ-008 SHALL have in_ready, output, 1 bit, block can accept.
REQ-009 SHALL have in_mode, input, 3 bits, extension mode.
REQ-010 SHALL have in_instr, input, DW bits, instruction word carrying the immediate or target field.
REQ-011 SHALL have in_pc, input, DW bits, PC of the instruction, used by the jump mode.
REQ-012 SHALL have out_valid, output, 1 bit, head entry present.
REQ-013 SHALL have out_ready, input, 1 bit, consumer accepts the head entry.
REQ-014 SHALL have out_data, output, DW bits, extended operand at the head.
REQ-015 SHALL have out_err, output, 1 bit, head entry had an illegal mode.
REQ-016 SHALL have count, output, 2 bits, buffer occupancy, 0 to 2.

Function
REQ-017 Push SHALL occur when in_valid and in_ready are both high at a rising edge; pop SHALL occur when out_valid and out_ready are both high.
REQ-018 Mode 000 SHALL zero-extend in_instr[IMM_W-1:0] to DW bits.
REQ-019 Mode 001 SHALL sign-extend in_instr[IMM_W-1:0] using bit IMM_W-1.
REQ-020 Mode 010 SHALL produce in_instr[IMM_W-1:0] shifted left by DW-IMM_W, with low bits zero.
REQ-021 Mode 011 SHALL produce the constant 1.
REQ-022 Mode 100 SHALL produce {in_pc[DW-1:J_W+BR_SHIFT], in_instr[J_W-1:0], BR_SHIFT zero bits}.
REQ-023 Mode 101 SHALL produce the sign-extended immediate shifted left by BR_SHIFT, truncated to DW bits.
REQ-024 Modes 110 and 111 SHALL produce out_data 0 with out_err 1; all legal modes SHALL produce out_err 0.
REQ-025 Extension SHALL be computed combinationally at push, and the result and error bit SHALL be stored in a 2-entry FIFO.
REQ-026 Latency SHALL be one cycle: an entry pushed at edge N into an empty buffer is visible on out_valid/out_data after edge N.
REQ-027 in_ready SHALL equal (count < 2) and SHALL NOT depend combinationally on out_ready.
REQ-028 out_valid SHALL equal (count > 0); out_data and out_err SHALL hold the head entry.
REQ-029 Entries SHALL leave in push order.
REQ-030 Simultaneous push and pop at count 1 SHALL leave count at 1, with the new entry becoming head.
REQ-031 At count 2 no push SHALL occur; a pop SHALL reduce count to 1.
REQ-032 Pop at count 0 SHALL be impossible, since out_valid is low.
REQ-033 While out_valid is high and out_ready is low, out_data and out_err SHALL remain stable.
REQ-034 Read and write pointers SHALL wrap modulo 2.

Reset
REQ-035 Asserting rst SHALL immediately force count=0, out_valid=0, out_data=0, out_err=0 and both pointers to 0, regardless of clk.
REQ-036 in_ready SHALL be 0 while rst is high and 1 in the first cycle after release.
REQ-037 Entries held when rst asserts mid-operation SHALL be discarded; no push or pop SHALL occur while rst is high.

Verification
REQ-038 Sign extension: mode 001, in_instr=0x0000_8004, out_ready=1 -> next cycle out_data=0xFFFF_8004, out_err=0.
REQ-039 Jump: mode 100, in_pc=0xA000_0000, in_instr=0x0000_0010 -> out_data=0xA000_0040.
REQ-040 Branch and upper: mode 101, imm 0xFFFF -> 0xFFFF_FFFC; mode 010, imm 0x1234 -> 0x1234_0000.
REQ-041 Backpressure: out_ready=0, three back-to-back offers -> two accepted, count=2, in_ready=0; then out_ready=1 -> both drain in order and in_ready returns to 1.
REQ-042 Illegal mode: mode 110 -> out_data=0, out_err=1; a following mode 011 entry -> out_data=1, out_err=0.
REQ-043 Reset mid-operation: count=2, assert rst between edges -> count=0 and out_valid=0 immediately; after release the first push appears one cycle later.
